// File: rtl/life_pixel_source.sv
// Game of Life pixel source for the 1280x1024 timing stage.
// Front bank feeds pixels; next generation is built into the back bank in vblank.
module life_pixel_source #(
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 64,
  parameter int CELL_SHIFT = 4,
  parameter int FRAME_DIV  = 8,
  parameter int X_ACTIVE   = 1280,
  parameter int Y_ACTIVE   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              video_on,
  input  logic              run,
  input  logic              step,
  input  logic              seed_we,
  input  logic [5:0]        seed_row,
  input  logic [GRID_W-1:0] seed_data,
  output logic              R,
  output logic              G,
  output logic              B,
  output logic              busy,
  output logic [15:0]       gen_count
);

  localparam int RW   = $clog2(GRID_H);
  localparam int CW   = $clog2(GRID_W);
  localparam int FW   = $clog2(FRAME_DIV);
  localparam int XLIM = GRID_W << CELL_SHIFT;
  localparam int YLIM = GRID_H << CELL_SHIFT;

  typedef enum logic {
    IDLE,
    COMPUTE
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              pend_q, pend_d;
  logic              front_q;
  logic              rgb_q, rgb_d;
  logic [15:0]       gen_q;
  logic [GRID_W-1:0] bank_q [2][GRID_H];

  logic              tick;
  logic              start;
  logic              last_row;
  logic              seed_ok;
  logic              in_grid;
  logic [RW-1:0]     row_m, row_p;
  logic [GRID_W-1:0] next_row;

  function automatic logic [GRID_W-1:0] life_row(
    input logic [GRID_W-1:0] up,
    input logic [GRID_W-1:0] mid,
    input logic [GRID_W-1:0] dn
  );
    logic [GRID_W-1:0] res;
    logic [CW-1:0]     l, c, r;
    logic [3:0]        n;
    res = '0;
    for (int i = 0; i < GRID_W; i++) begin
      c = CW'(i);
      l = (i == 0) ? CW'(GRID_W - 1) : CW'(i - 1);
      r = (i == GRID_W - 1) ? '0 : CW'(i + 1);
      n = 4'(up[l]) + 4'(up[c]) + 4'(up[r])
        + 4'(mid[l]) + 4'(mid[r])
        + 4'(dn[l]) + 4'(dn[c]) + 4'(dn[r]);
      res[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
    end
    return res;
  endfunction

  assign tick     = (32'(x) == 0) && (32'(y) == Y_ACTIVE);
  assign last_row = (row_q == RW'(GRID_H - 1));
  assign start    = (state_q == IDLE) && tick &&
                    (pend_q || (run && fcnt_q == FW'(FRAME_DIV - 1)));
  assign seed_ok  = (state_q == IDLE) && seed_we &&
                    (32'(seed_row) < GRID_H);

  assign row_m    = (row_q == '0) ? RW'(GRID_H - 1) : row_q - 1'b1;
  assign row_p    = last_row ? '0 : row_q + 1'b1;
  assign next_row = life_row(bank_q[front_q][row_m],
                             bank_q[front_q][row_q],
                             bank_q[front_q][row_p]);

  assign in_grid  = video_on &&
                    (32'(x) < XLIM) && (32'(x) < X_ACTIVE) &&
                    (32'(y) < YLIM) && (32'(y) < Y_ACTIVE);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          row_d   = '0;
        end
      end
      COMPUTE: begin
        row_d = row_q + 1'b1;
        if (last_row) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (start) pend_d = 1'b0;
    if (step)  pend_d = 1'b1;
    fcnt_d = fcnt_q;
    if (!run)
      fcnt_d = '0;
    else if (tick)
      fcnt_d = (fcnt_q == FW'(FRAME_DIV - 1)) ? '0 : fcnt_q + 1'b1;
    rgb_d = in_grid &
      bank_q[front_q][y[CELL_SHIFT +: RW]][x[CELL_SHIFT +: CW]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      front_q <= 1'b0;
      rgb_q   <= 1'b0;
      gen_q   <= '0;
      for (int h = 0; h < GRID_H; h++) begin
        bank_q[0][h] <= '0;
        bank_q[1][h] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      rgb_q   <= rgb_d;
      if (state_q == COMPUTE)
        bank_q[~front_q][row_q] <= next_row;
      if (seed_ok)
        bank_q[front_q][seed_row[RW-1:0]] <= seed_data;
      // swap lands on the last row edge, always inside vblank
      if (state_q == COMPUTE && last_row) begin
        front_q <= ~front_q;
        gen_q   <= gen_q + 16'd1;
      end
    end
  end

  assign R         = rgb_q;
  assign G         = rgb_q;
  assign B         = rgb_q;
  assign busy      = (state_q == COMPUTE);
  assign gen_count = gen_q;

endmodule
